// File: rtl/id_regfile_sb_if.sv
// Bundles the decode-stage read, issue and writeback signals of id_regfile_sb.
// No storage: pure wiring between the ID stage controller and the register file.
// Backpressure is the combinational stall/issue_ack pair driven by the slave.
interface id_regfile_sb_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    // Read ports, packed as port i at [i*AW +: AW] / [i*WIDTH +: WIDTH]
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD-1:0]       rd_used;
    logic [NREAD*WIDTH-1:0] rd_data;

    // Issue handshake from IF/ID
    logic                   issue_valid;
    logic                   issue_wr;
    logic [AW-1:0]          issue_rd;
    logic                   issue_ack;
    logic                   stall;

    // Writeback from MEM/WB
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;

    // Pipeline control and status
    logic                   flush;
    logic                   sb_err;

    modport master (
        output rd_addr, rd_used, issue_valid, issue_wr, issue_rd,
               wr_en, wr_addr, wr_data, flush,
        input  rd_data, issue_ack, stall, sb_err
    );

    modport slave (
        input  rd_addr, rd_used, issue_valid, issue_wr, issue_rd,
               wr_en, wr_addr, wr_data, flush,
        output rd_data, issue_ack, stall, sb_err
    );
endinterface

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with a saturating per-register pending-write scoreboard.
// Reads, stall and issue_ack are combinational (0 cycles); writes and counters update at the edge.
// Stalls an issue that reads a pending register or would push its destination past MAXPEND.
module id_regfile_sb #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 32,
    parameter int NREAD   = 2,
    parameter int BYPASS  = 1,
    parameter int MAXPEND = 3
) (
    input  logic             clk,
    input  logic             rst,
    id_regfile_sb_if.slave   bus
);
    // The interface instance must be built with the matching AW/WIDTH/NREAD.
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(MAXPEND + 1);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [CW-1:0]    pend_q [NREGS];
    logic [CW-1:0]    pend_d [NREGS];
    logic             sb_err_q;
    logic             sb_err_d;

    logic [AW-1:0]          rd_a [NREAD];
    logic [NREGS-1:0]       clr_v;
    logic [NREGS-1:0]       inc_v;
    logic [NREGS-1:0]       dec_v;
    logic [NREAD*WIDTH-1:0] rd_data_c;
    logic                   src_haz;
    logic                   dst_haz;
    logic                   stall_c;
    logic                   ack_c;

    // Unpack read addresses and decode which register this cycle's writeback retires.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_a[i] = bus.rd_addr[i*AW +: AW];
        end
        clr_v = '0;
        for (int r = 1; r < NREGS; r++) begin
            clr_v[r] = bus.wr_en && (bus.wr_addr == AW'(r));
        end
    end

    // Read muxes and source hazards; a bypassed writeback retiring the last pending write unblocks the read.
    always_comb begin
        rd_data_c = '0;
        src_haz   = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_a[i] != '0) begin
                if (BYPASS == 1 && bus.wr_en && bus.wr_addr == rd_a[i]) begin
                    rd_data_c[i*WIDTH +: WIDTH] = bus.wr_data;
                end else begin
                    rd_data_c[i*WIDTH +: WIDTH] = regs_q[rd_a[i]];
                end
                if (bus.rd_used[i] && pend_q[rd_a[i]] != '0 &&
                    !(BYPASS == 1 && clr_v[rd_a[i]] && pend_q[rd_a[i]] == CW'(1))) begin
                    src_haz = 1'b1;
                end
            end
        end
    end

    // Destination hazard keeps the counter from exceeding MAXPEND; a same-cycle writeback frees a slot.
    always_comb begin
        dst_haz = bus.issue_wr && (bus.issue_rd != '0) &&
                  (pend_q[bus.issue_rd] == CW'(MAXPEND)) && !clr_v[bus.issue_rd];
        stall_c = bus.issue_valid && (src_haz || dst_haz);
        ack_c   = bus.issue_valid && !stall_c;
    end

    // Per-register increment (accepted issue) and decrement (retiring writeback) requests.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc_v[r] = ack_c && bus.issue_wr && (bus.issue_rd == AW'(r));
            dec_v[r] = clr_v[r] && (pend_q[r] != '0);
        end
    end

    // Next state: register writes always land; flush zeroes counters; underflow is sticky in sb_err.
    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            pend_d[r] = pend_q[r];
            if (clr_v[r]) begin
                regs_d[r] = bus.wr_data;
                if (pend_q[r] == '0) begin
                    sb_err_d = 1'b1;
                end
            end
            if (bus.flush) begin
                pend_d[r] = '0;
            end else if (inc_v[r] && !dec_v[r]) begin
                pend_d[r] = pend_q[r] + CW'(1);
            end else if (dec_v[r] && !inc_v[r]) begin
                pend_d[r] = pend_q[r] - CW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
                pend_q[r] <= pend_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.stall     = stall_c;
    assign bus.issue_ack = ack_c;
    assign bus.sb_err    = sb_err_q;
endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 instance see identical stimulus.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Dependent-read issues never write a destination, so both scoreboards stay in step.
module tb_id_regfile_sb;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NREAD = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_regfile_sb_if #(.WIDTH(WIDTH), .AW(AW), .NREAD(NREAD)) b1 ();
    id_regfile_sb_if #(.WIDTH(WIDTH), .AW(AW), .NREAD(NREAD)) b0 ();

    id_regfile_sb #(.BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    id_regfile_sb #(.BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    logic [NREAD*AW-1:0] rd_addr     = '0;
    logic [NREAD-1:0]    rd_used     = '0;
    logic                issue_valid = 1'b0;
    logic                issue_wr    = 1'b0;
    logic [AW-1:0]       issue_rd    = '0;
    logic                wr_en       = 1'b0;
    logic [AW-1:0]       wr_addr     = '0;
    logic [WIDTH-1:0]    wr_data     = '0;
    logic                flush       = 1'b0;

    assign b1.rd_addr = rd_addr;     assign b0.rd_addr = rd_addr;
    assign b1.rd_used = rd_used;     assign b0.rd_used = rd_used;
    assign b1.issue_valid = issue_valid; assign b0.issue_valid = issue_valid;
    assign b1.issue_wr = issue_wr;   assign b0.issue_wr = issue_wr;
    assign b1.issue_rd = issue_rd;   assign b0.issue_rd = issue_rd;
    assign b1.wr_en = wr_en;         assign b0.wr_en = wr_en;
    assign b1.wr_addr = wr_addr;     assign b0.wr_addr = wr_addr;
    assign b1.wr_data = wr_data;     assign b0.wr_data = wr_data;
    assign b1.flush = flush;         assign b0.flush = flush;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        rd_addr = '0; rd_used = '0; issue_valid = 1'b0; issue_wr = 1'b0;
        issue_rd = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; flush = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] rd);
        issue_valid = 1'b1; issue_wr = wr; issue_rd = rd;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        idle();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        settle();

        // 1: reset state
        for (int r = 0; r < 32; r++) begin
            ra = AW'(r);
            rd_addr = {ra, ra};
            settle();
            chk("reset_rd", {b1.rd_data, b0.rd_data}, 128'h0);
        end
        chk("reset_stall", {b1.stall, b0.stall}, 2'b00);
        chk("reset_sb_err", {b1.sb_err, b0.sb_err}, 2'b00);
        idle();

        // 2: write x5 with bypass visibility
        issue(1'b1, 5'd5); settle();
        chk("x5_issue_ack", {b1.issue_ack, b0.issue_ack}, 2'b11);
        tick(); idle();
        wb(5'd5, 32'hDEADBEEF); rd_addr = {5'd0, 5'd5}; settle();
        chk("x5_bypass1", b1.rd_data[31:0], 32'hDEADBEEF);
        chk("x5_bypass0", b0.rd_data[31:0], 32'h0);
        tick(); wr_en = 1'b0; settle();
        chk("x5_next1", b1.rd_data[31:0], 32'hDEADBEEF);
        chk("x5_next0", b0.rd_data[31:0], 32'hDEADBEEF);
        wb(5'd0, 32'h1234); rd_addr = {5'd0, 5'd0}; settle();
        chk("x0_same", {b1.rd_data, b0.rd_data}, 128'h0);
        tick(); wr_en = 1'b0; settle();
        chk("x0_next", {b1.rd_data, b0.rd_data}, 128'h0);
        chk("x0_no_err", {b1.sb_err, b0.sb_err}, 2'b00);
        idle();

        // 3: RAW on x7
        issue(1'b1, 5'd7); settle();
        chk("x7_issue_ack", {b1.issue_ack, b0.issue_ack}, 2'b11);
        tick(); idle();
        issue(1'b0, 5'd0); rd_addr = {5'd0, 5'd7}; rd_used = 2'b01; settle();
        chk("x7_raw_stall", {b1.stall, b0.stall}, 2'b11);
        chk("x7_raw_ack", {b1.issue_ack, b0.issue_ack}, 2'b00);
        tick();
        wb(5'd7, 32'h42); settle();
        chk("x7_wb_stall", {b1.stall, b0.stall}, 2'b01);
        chk("x7_wb_ack", {b1.issue_ack, b0.issue_ack}, 2'b10);
        chk("x7_wb_rd1", b1.rd_data[31:0], 32'h42);
        tick(); wr_en = 1'b0; settle();
        chk("x7_after_stall", {b1.stall, b0.stall}, 2'b00);
        chk("x7_after_rd0", b0.rd_data[31:0], 32'h42);
        tick(); idle();

        // 4: saturate x3 at MAXPEND
        issue(1'b1, 5'd3);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("x3_fill_ack", {b1.issue_ack, b0.issue_ack}, 2'b11);
            tick();
        end
        settle();
        chk("x3_full_stall", {b1.stall, b0.stall}, 2'b11);
        chk("x3_full_ack", {b1.issue_ack, b0.issue_ack}, 2'b00);
        tick();
        wb(5'd3, 32'h33); settle();
        chk("x3_wb_issue_ack", {b1.issue_ack, b0.issue_ack}, 2'b11);
        tick(); wr_en = 1'b0; settle();
        chk("x3_still_full", {b1.stall, b0.stall}, 2'b11);
        idle();
        wb(5'd3, 32'h34); tick();
        issue(1'b0, 5'd0); rd_addr = {5'd3, 5'd0}; rd_used = 2'b10; settle();
        chk("x3_pend2_src", {b1.stall, b0.stall}, 2'b11);
        tick(); settle();
        chk("x3_pend1_src", {b1.stall, b0.stall}, 2'b01);
        tick(); wr_en = 1'b0; settle();
        chk("x3_drained", {b1.stall, b0.stall}, 2'b00);
        chk("x3_no_err", {b1.sb_err, b0.sb_err}, 2'b00);
        idle();

        // 5: flush then underflow on x9
        issue(1'b1, 5'd9); tick(); tick();
        flush = 1'b1; settle();
        chk("x9_flush_ack", {b1.issue_ack, b0.issue_ack}, 2'b11);
        tick(); idle();
        issue(1'b0, 5'd0); rd_addr = {5'd0, 5'd9}; rd_used = 2'b01; settle();
        chk("x9_cleared", {b1.stall, b0.stall}, 2'b00);
        idle();
        wb(5'd9, 32'h99); settle();
        chk("x9_err_pre", {b1.sb_err, b0.sb_err}, 2'b00);
        tick(); idle(); rd_addr = {5'd0, 5'd9}; settle();
        chk("x9_err_set", {b1.sb_err, b0.sb_err}, 2'b11);
        chk("x9_written", {b1.rd_data[31:0], b0.rd_data[31:0]}, 64'h00000099_00000099);
        tick(); tick(); settle();
        chk("x9_err_sticky", {b1.sb_err, b0.sb_err}, 2'b11);

        // 6: reset mid-sequence
        issue(1'b1, 5'd4); tick(); idle();
        issue(1'b0, 5'd0); rd_addr = {5'd0, 5'd4}; rd_used = 2'b01; settle();
        chk("x4_pend_stall", {b1.stall, b0.stall}, 2'b11);
        rst = 1'b0; settle();
        chk("x4_stall_in_rst", {b1.stall, b0.stall}, 2'b11);
        tick(); rst = 1'b1; settle();
        chk("x4_rst_stall", {b1.stall, b0.stall}, 2'b00);
        chk("x4_rst_err", {b1.sb_err, b0.sb_err}, 2'b00);
        rd_addr = {5'd7, 5'd5}; settle();
        chk("x5_x7_rst", {b1.rd_data, b0.rd_data}, 128'h0);
        rd_addr = {5'd3, 5'd9}; settle();
        chk("x3_x9_rst", {b1.rd_data, b0.rd_data}, 128'h0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
